// File: rtl/bus_xcvr_ctrl.sv
// Round-robin sequencer for one octal inverting bus transceiver (74648 style).
// Enforces OE_n high around every DIR change and issues stored-mode capture clocks.
`timescale 1ns/1ps
module bus_xcvr_ctrl #(
  parameter int TURN_CYCLES = 2,
  parameter int XFER_CYCLES = 1
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic REQ_AB,
  input  logic STORED_AB,
  input  logic REQ_BA,
  input  logic STORED_BA,
  output logic GNT_AB,
  output logic GNT_BA,
  output logic DONE_AB,
  output logic DONE_BA,
  output logic BUSY,
  output logic DIR,
  output logic OE_n,
  output logic SAB,
  output logic SBA,
  output logic CLKAB,
  output logic CLKBA
);
  localparam int MAXC = (TURN_CYCLES > XFER_CYCLES) ? TURN_CYCLES : XFER_CYCLES;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] XFER_LD = CW'(XFER_CYCLES - 1);
  localparam logic ONE_XFER = (XFER_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, CAPT, TURN, XFER} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          dir_new_q, stored_q, last_ab_q;
  logic          gnt_ab_q, gnt_ba_q, done_ab_q, done_ba_q, busy_q;
  logic          dir_q, oe_n_q, sab_q, sba_q, clkab_q, clkba_q;

  // Grant AB unless BA also wants the bus and AB was served last.
  logic pick_ab, pick_st, any_req;
  assign any_req = REQ_AB | REQ_BA;
  assign pick_ab = REQ_AB & (~REQ_BA | ~last_ab_q);
  assign pick_st = pick_ab ? STORED_AB : STORED_BA;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_new_q <= 1'b0;
      stored_q  <= 1'b0;
      last_ab_q <= 1'b0;
      gnt_ab_q  <= 1'b0;
      gnt_ba_q  <= 1'b0;
      done_ab_q <= 1'b0;
      done_ba_q <= 1'b0;
      busy_q    <= 1'b0;
      dir_q     <= 1'b0;
      oe_n_q    <= 1'b1;
      sab_q     <= 1'b0;
      sba_q     <= 1'b0;
      clkab_q   <= 1'b0;
      clkba_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_ab_q  <= pick_ab;
          gnt_ba_q  <= ~pick_ab;
          last_ab_q <= pick_ab;
          dir_new_q <= pick_ab;
          stored_q  <= pick_st;
          busy_q    <= 1'b1;
          if (pick_st) begin
            state_q <= CAPT;
            clkab_q <= pick_ab;
            clkba_q <= ~pick_ab;
          end else if (dir_q != pick_ab) begin
            state_q <= TURN;
            dir_q   <= pick_ab;
            cnt_q   <= TURN_LD;
          end else begin
            // Real-time, same direction: straight to the enabled phase.
            state_q   <= XFER;
            oe_n_q    <= 1'b0;
            cnt_q     <= XFER_LD;
            done_ab_q <= pick_ab & ONE_XFER;
            done_ba_q <= ~pick_ab & ONE_XFER;
          end
        end
        CAPT: begin
          clkab_q <= 1'b0;
          clkba_q <= 1'b0;
          if (dir_q != dir_new_q) begin
            state_q <= TURN;
            dir_q   <= dir_new_q;
            cnt_q   <= TURN_LD;
          end else begin
            state_q   <= XFER;
            oe_n_q    <= 1'b0;
            cnt_q     <= XFER_LD;
            sab_q     <= dir_new_q & stored_q;
            sba_q     <= ~dir_new_q & stored_q;
            done_ab_q <= dir_new_q & ONE_XFER;
            done_ba_q <= ~dir_new_q & ONE_XFER;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q   <= XFER;
            oe_n_q    <= 1'b0;
            cnt_q     <= XFER_LD;
            sab_q     <= dir_new_q & stored_q;
            sba_q     <= ~dir_new_q & stored_q;
            done_ab_q <= dir_new_q & ONE_XFER;
            done_ba_q <= ~dir_new_q & ONE_XFER;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        XFER: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            oe_n_q    <= 1'b1;
            gnt_ab_q  <= 1'b0;
            gnt_ba_q  <= 1'b0;
            done_ab_q <= 1'b0;
            done_ba_q <= 1'b0;
            sab_q     <= 1'b0;
            sba_q     <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - CW'(1);
            done_ab_q <= dir_new_q & (cnt_q == CW'(1));
            done_ba_q <= ~dir_new_q & (cnt_q == CW'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT_AB  = gnt_ab_q;
  assign GNT_BA  = gnt_ba_q;
  assign DONE_AB = done_ab_q;
  assign DONE_BA = done_ba_q;
  assign BUSY    = busy_q;
  assign DIR     = dir_q;
  assign OE_n    = oe_n_q;
  assign SAB     = sab_q;
  assign SBA     = sba_q;
  assign CLKAB   = clkab_q;
  assign CLKBA   = clkba_q;
endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// Directed bench for bus_xcvr_ctrl: default build plus a TURN=1/XFER=3 build.
`timescale 1ns/1ps
module tb_bus_xcvr_ctrl;
  logic sysclk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic req_ab = 0, st_ab = 0, req_ba = 0, st_ba = 0;
  logic gnt_ab, gnt_ba, done_ab, done_ba, busy, dir, oe_n, sab, sba, clkab, clkba;
  logic req_ab2 = 0, st_ab2 = 0, req_ba2 = 0, st_ba2 = 0;
  logic gnt_ab2, gnt_ba2, done_ab2, done_ba2, busy2, dir2, oe_n2, sab2, sba2, clkab2, clkba2;
  int checks = 0;
  int errors = 0;
  logic prev_dir = 1'b0, prev_dir2 = 1'b0;

  always #5 sysclk = ~sysclk;

  bus_xcvr_ctrl u_dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n),
    .REQ_AB(req_ab), .STORED_AB(st_ab), .REQ_BA(req_ba), .STORED_BA(st_ba),
    .GNT_AB(gnt_ab), .GNT_BA(gnt_ba), .DONE_AB(done_ab), .DONE_BA(done_ba),
    .BUSY(busy), .DIR(dir), .OE_n(oe_n), .SAB(sab), .SBA(sba),
    .CLKAB(clkab), .CLKBA(clkba)
  );

  bus_xcvr_ctrl #(.TURN_CYCLES(1), .XFER_CYCLES(3)) u_dut2 (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n),
    .REQ_AB(req_ab2), .STORED_AB(st_ab2), .REQ_BA(req_ba2), .STORED_BA(st_ba2),
    .GNT_AB(gnt_ab2), .GNT_BA(gnt_ba2), .DONE_AB(done_ab2), .DONE_BA(done_ba2),
    .BUSY(busy2), .DIR(dir2), .OE_n(oe_n2), .SAB(sab2), .SBA(sba2),
    .CLKAB(clkab2), .CLKBA(clkba2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Safety invariants on both builds, every cycle.
  always @(negedge sysclk) begin
    if (sys_rst_n) begin
      if (!oe_n) begin
        chk("dir_stable", dir, prev_dir);
        chk("clkab_vs_oe", clkab, 1'b0);
        chk("clkba_vs_oe", clkba, 1'b0);
      end
      if (!oe_n2) begin
        chk("dir2_stable", dir2, prev_dir2);
        chk("clkab2_vs_oe", clkab2, 1'b0);
        chk("clkba2_vs_oe", clkba2, 1'b0);
      end
    end
    prev_dir  <= dir;
    prev_dir2 <= dir2;
  end

  initial begin
    #12;
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_dir", dir, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt_ab", gnt_ab, 1'b0);
    chk("rst_clkab", clkab, 1'b0);
    chk("rst_sab", sab, 1'b0);
    sys_rst_n = 1'b1;
    tick();

    // Real-time A->B after reset: DIR turns, 2 cycles OE_n high, then 1 enabled cycle.
    req_ab = 1;
    tick();
    chk("t2_k1_dir", dir, 1'b1);
    chk("t2_k1_oe", oe_n, 1'b1);
    chk("t2_k1_gnt", gnt_ab, 1'b1);
    chk("t2_k1_busy", busy, 1'b1);
    chk("t2_k1_done", done_ab, 1'b0);
    tick();
    chk("t2_k2_oe", oe_n, 1'b1);
    chk("t2_k2_done", done_ab, 1'b0);
    tick();
    chk("t2_k3_oe", oe_n, 1'b0);
    chk("t2_k3_done", done_ab, 1'b1);
    chk("t2_k3_sab", sab, 1'b0);
    req_ab = 0;
    tick();
    chk("t2_k4_busy", busy, 1'b0);
    chk("t2_k4_oe", oe_n, 1'b1);
    chk("t2_k4_gnt", gnt_ab, 1'b0);
    chk("t2_k4_done", done_ab, 1'b0);
    chk("t2_k4_dir", dir, 1'b1);

    // Same direction back to back: no turnaround, enabled cycles 2 apart.
    req_ab = 1;
    tick();
    chk("t3_a_oe", oe_n, 1'b0);
    chk("t3_a_gnt", gnt_ab, 1'b1);
    chk("t3_a_done", done_ab, 1'b1);
    tick();
    chk("t3_gap_oe", oe_n, 1'b1);
    chk("t3_gap_busy", busy, 1'b0);
    chk("t3_gap_gnt", gnt_ab, 1'b0);
    tick();
    chk("t3_b_oe", oe_n, 1'b0);
    chk("t3_b_done", done_ab, 1'b1);

    // Asynchronous reset in the middle of a transfer.
    sys_rst_n = 1'b0;
    req_ab = 0;
    #1;
    chk("t1_oe", oe_n, 1'b1);
    chk("t1_dir", dir, 1'b0);
    chk("t1_gnt", gnt_ab, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done_ab, 1'b0);
    #2;
    sys_rst_n = 1'b1;
    tick();

    // Simultaneous requests: AB first, BA next, then AB again.
    req_ab = 1; req_ba = 1;
    tick();
    chk("t4_ab_gnt", gnt_ab, 1'b1);
    chk("t4_ab_gntba", gnt_ba, 1'b0);
    chk("t4_ab_dir", dir, 1'b1);
    tick();
    chk("t4_ab_turn_oe", oe_n, 1'b1);
    tick();
    chk("t4_ab_done", done_ab, 1'b1);
    chk("t4_ab_oe", oe_n, 1'b0);
    req_ab = 0;
    tick();
    chk("t4_idle1", busy, 1'b0);
    tick();
    chk("t4_ba_gnt", gnt_ba, 1'b1);
    chk("t4_ba_gntab", gnt_ab, 1'b0);
    chk("t4_ba_dir", dir, 1'b0);
    chk("t4_ba_oe1", oe_n, 1'b1);
    tick();
    chk("t4_ba_oe2", oe_n, 1'b1);
    tick();
    chk("t4_ba_oe3", oe_n, 1'b0);
    chk("t4_ba_done", done_ba, 1'b1);
    req_ab = 1;
    tick();
    chk("t4_idle2", busy, 1'b0);
    tick();
    chk("t4_rr_gnt_ab", gnt_ab, 1'b1);
    chk("t4_rr_gnt_ba", gnt_ba, 1'b0);
    chk("t4_rr_dir", dir, 1'b1);
    tick();
    tick();
    chk("t4_rr_done", done_ab, 1'b1);
    req_ab = 0;
    tick();
    tick();
    chk("t4_last_gnt_ba", gnt_ba, 1'b1);
    tick();
    tick();
    chk("t4_last_done", done_ba, 1'b1);
    req_ba = 0;
    tick();
    chk("t4_end_dir", dir, 1'b0);

    // Stored B->A, no turnaround: one capture pulse, then stored drive.
    req_ba = 1; st_ba = 1;
    tick();
    req_ba = 0; st_ba = 0;
    chk("t5_clkba", clkba, 1'b1);
    chk("t5_capt_oe", oe_n, 1'b1);
    chk("t5_capt_sba", sba, 1'b0);
    chk("t5_capt_gnt", gnt_ba, 1'b1);
    tick();
    chk("t5_x_clkba", clkba, 1'b0);
    chk("t5_x_sba", sba, 1'b1);
    chk("t5_x_oe", oe_n, 1'b0);
    chk("t5_x_done", done_ba, 1'b1);
    tick();
    chk("t5_idle_sba", sba, 1'b0);
    chk("t5_idle_oe", oe_n, 1'b1);

    // Stored A->B with a direction change: capture, turn, then stored drive.
    req_ab = 1; st_ab = 1;
    tick();
    chk("t5b_clkab", clkab, 1'b1);
    chk("t5b_capt_dir", dir, 1'b0);
    tick();
    chk("t5b_turn_clkab", clkab, 1'b0);
    chk("t5b_turn_dir", dir, 1'b1);
    tick();
    chk("t5b_turn2_oe", oe_n, 1'b1);
    tick();
    chk("t5b_x_sab", sab, 1'b1);
    chk("t5b_x_done", done_ab, 1'b1);
    req_ab = 0; st_ab = 0;
    tick();
    chk("t5b_idle_sab", sab, 1'b0);

    // Second build: TURN_CYCLES=1, XFER_CYCLES=3.
    req_ab2 = 1;
    tick();
    chk("t6_dir", dir2, 1'b1);
    chk("t6_turn_oe", oe_n2, 1'b1);
    tick();
    chk("t6_x1_oe", oe_n2, 1'b0);
    chk("t6_x1_done", done_ab2, 1'b0);
    tick();
    chk("t6_x2_oe", oe_n2, 1'b0);
    chk("t6_x2_done", done_ab2, 1'b0);
    tick();
    chk("t6_x3_oe", oe_n2, 1'b0);
    chk("t6_x3_done", done_ab2, 1'b1);
    chk("t6_x3_gnt", gnt_ab2, 1'b1);
    req_ab2 = 0;
    tick();
    chk("t6_idle_oe", oe_n2, 1'b1);
    chk("t6_idle_busy", busy2, 1'b0);
    chk("t6_idle_done", done_ab2, 1'b0);

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
